// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Counter width covers the largest legal load latency and branch penalty.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LDSTALL = 2'd1,
    BRFLUSH = 2'd2
  } hazState_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  localparam int NUM_FWD_STAGES = 3;
  localparam int LOAD_LAT_MAX   = 4;
  localparam int BR_PENALTY_MAX = 3;

  function automatic int cntWidth(input int loadLat, input int brPenalty);
    return $clog2(((loadLat > brPenalty) ? loadLat : brPenalty) + 1);
  endfunction

  localparam int CNT_W = cntWidth(LOAD_LAT_MAX, BR_PENALTY_MAX);

endpackage

// File: rtl/hazard_match.sv
// Compares one source register address against the E, M and W destinations.
// Register 0 is hardwired zero, so it never produces a match.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] srcAdd,
  input  logic              srcEn,
  input  logic [REG_AW-1:0] destAddE,
  input  logic [REG_AW-1:0] destAddM,
  input  logic [REG_AW-1:0] destAddW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              matchE,
  output logic              matchM,
  output logic              matchW
);

  logic [NUM_FWD_STAGES-1:0][REG_AW-1:0] destVec;
  logic [NUM_FWD_STAGES-1:0]             wrVec;
  logic [NUM_FWD_STAGES-1:0]             hitVec;

  // Index 0 = E, 1 = M, 2 = W
  assign destVec = {destAddW, destAddM, destAddE};
  assign wrVec   = {RegWriteW, RegWriteM, RegWriteE};

  generate
    for (genvar gi = 0; gi < NUM_FWD_STAGES; gi++) begin : gStage
      assign hitVec[gi] = srcEn & wrVec[gi] & (destVec[gi] == srcAdd) &
                          (destVec[gi] != '0);
    end
  endgenerate

  assign matchE = hitVec[0];
  assign matchM = hitVec[1];
  assign matchW = hitVec[2];

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Hazard and forwarding controller for the 5-stage pipeline: E-operand forwarding,
// multi-cycle load-use stall, D-stage branch resolution with interlock and flush window.
module hazard_ctrl_pipe
  import hazard_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] srcAdd1D,
  input  logic [REG_AW-1:0] srcAdd2D,
  input  logic              useSrc2D,
  input  logic              branchD,
  input  logic              brNeD,
  input  logic [DATA_W-1:0] srcData1D,
  input  logic [DATA_W-1:0] srcData2D,
  input  logic [REG_AW-1:0] destAddE,
  input  logic [REG_AW-1:0] destAddM,
  input  logic [REG_AW-1:0] destAddW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              fwdBrA,
  output logic              fwdBrB,
  output logic              brTaken
);

  localparam int CNT_BITS = cntWidth(LOAD_LAT, BR_PENALTY);

  // The first stall/flush cycle happens in IDLE, so the counters cover the rest.
  localparam logic [CNT_BITS-1:0] LD_INIT =
    (LOAD_LAT > 1) ? CNT_BITS'(LOAD_LAT - 2) : '0;
  localparam logic [CNT_BITS-1:0] BR_INIT =
    (BR_PENALTY > 1) ? CNT_BITS'(BR_PENALTY - 2) : '0;

  hazState_t           stateReg, stateNext;
  logic [CNT_BITS-1:0] cntReg, cntNext;

  logic match1E, match1M, match1W;
  logic match2E, match2M, match2W;

  logic loadUse, brInterlock, brCond;
  logic stallAll, flushDInt, brTakenInt;
  logic [1:0] fwdAInt, fwdBInt;

  hazard_match #(.REG_AW(REG_AW)) uMatch1 (
    .srcAdd    (srcAdd1D),
    .srcEn     (1'b1),
    .destAddE  (destAddE),
    .destAddM  (destAddM),
    .destAddW  (destAddW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .matchE    (match1E),
    .matchM    (match1M),
    .matchW    (match1W)
  );

  hazard_match #(.REG_AW(REG_AW)) uMatch2 (
    .srcAdd    (srcAdd2D),
    .srcEn     (useSrc2D),
    .destAddE  (destAddE),
    .destAddM  (destAddM),
    .destAddW  (destAddW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .matchE    (match2E),
    .matchM    (match2M),
    .matchW    (match2W)
  );

  assign fwdAInt = match1M ? FWD_M : (match1W ? FWD_W : FWD_RF);
  assign fwdBInt = match2M ? FWD_M : (match2W ? FWD_W : FWD_RF);

  assign loadUse     = MemToRegE & (match1E | match2E);
  // Branch compares in D: an E producer or an M load cannot be forwarded yet.
  assign brInterlock = branchD & (match1E | match2E | (MemToRegM & (match1M | match2M)));
  assign brCond      = (srcData1D == srcData2D) ^ brNeD;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    stallAll   = 1'b0;
    flushDInt  = 1'b0;
    brTakenInt = 1'b0;
    case (stateReg)
      IDLE: begin
        if (loadUse) begin
          stallAll = 1'b1;
          if (LOAD_LAT > 1) begin
            stateNext = LDSTALL;
            cntNext   = LD_INIT;
          end
        end else if (brInterlock) begin
          stallAll = 1'b1;
        end else if (branchD && brCond) begin
          brTakenInt = 1'b1;
          flushDInt  = 1'b1;
          if (BR_PENALTY > 1) begin
            stateNext = BRFLUSH;
            cntNext   = BR_INIT;
          end
        end
      end
      LDSTALL: begin
        stallAll = 1'b1;
        if (cntReg == '0) begin
          stateNext = IDLE;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      BRFLUSH: begin
        flushDInt = 1'b1;
        if (cntReg == '0) begin
          stateNext = IDLE;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Held in reset, every output is forced low whatever the inputs do.
  assign stallF  = reset_n & stallAll;
  assign stallD  = reset_n & stallAll;
  assign flushE  = reset_n & stallAll;
  assign flushD  = reset_n & flushDInt;
  assign brTaken = reset_n & brTakenInt;
  assign fwdA    = reset_n ? fwdAInt : FWD_RF;
  assign fwdB    = reset_n ? fwdBInt : FWD_RF;
  assign fwdBrA  = reset_n & match1M & ~MemToRegM;
  assign fwdBrB  = reset_n & match2M & ~MemToRegM;

endmodule
